inst_mem_resp: RTL and testbench

//  Instruction-memory responder: the memory end of the fetch interface.

---
 rtl/inst_mem_resp.sv | 118 +++++++++++
 tb/tb_inst_mem_resp.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: word array read one cycle after accept, then queued in a response FIFO.
// Optional INST_MEM_ERR_EN adds inst_err_o for misaligned / out-of-range fetches.
module inst_mem_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic [31:0] pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_data_o,
  output logic [31:0] inst_pc_o,
  input  logic        flush_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i
`ifdef INST_MEM_ERR_EN
  ,
  output logic        inst_err_o
`endif
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } resp_t;

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] rd_idx, wr_idx;
  logic                  accept, push, pop, req_err;
  logic                  s1_valid, s1_err;
  logic [31:0]           s1_pc, s1_rd;
  resp_t                 fifo [FIFO_DEPTH];
  resp_t                 head;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [CW:0]           occ;

  assign rd_idx = pc_i[ADDR_WIDTH+1:2];
  assign wr_idx = wr_addr_i[ADDR_WIDTH+1:2];

`ifdef INST_MEM_ERR_EN
  assign req_err = (pc_i[1:0] != 2'b00) || ((pc_i >> (ADDR_WIDTH + 2)) != 32'd0);
`else
  assign req_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc_i[1:0], pc_i[31:ADDR_WIDTH+2]};
`endif
  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_addr_i[1:0], wr_addr_i[31:ADDR_WIDTH+2]};

  // Ready depends only on registered occupancy so the FIFO can always absorb what s1 holds.
  assign occ        = (CW+1)'(count) + (CW+1)'(s1_valid);
  assign pc_ready_o = !rst && (occ < (CW+1)'(FIFO_DEPTH));
  assign accept     = pc_valid_i && pc_ready_o;
  assign push       = s1_valid;
  assign pop        = inst_valid_o && inst_ready_i;

  // Read-first: a same-edge write is not visible to the read registered here.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_idx] <= wr_data_i;
    if (accept && !req_err) s1_rd <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      s1_valid <= 1'b0;
      s1_pc    <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pc  <= pc_i;
        s1_err <= req_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{data: s1_err ? NOP : s1_rd, pc: s1_pc, err: s1_err};
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outputs are forced to zero while empty so reset/flush show clean values.
  assign head         = fifo[rd_ptr];
  assign inst_valid_o = (count != '0);
  assign inst_data_o  = inst_valid_o ? head.data : '0;
  assign inst_pc_o    = inst_valid_o ? head.pc   : '0;
`ifdef INST_MEM_ERR_EN
  assign inst_err_o   = inst_valid_o && head.err;
`else
  logic unused_err;
  assign unused_err = head.err;
`endif

endmodule

// File: tb/tb_inst_mem_resp.sv
// Randomized self-checking bench for inst_mem_resp against a queue-based transaction model.
module tb_inst_mem_resp;
  localparam int AW = 10;
  localparam int DEPTH = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst, pc_valid, pc_ready, inst_valid, inst_ready, flush, wr_en;
  logic [31:0] pc, inst_data, inst_pc, wr_addr, wr_data;
`ifdef INST_MEM_ERR_EN
  logic inst_err;
`endif

  always #5 clk = ~clk;

  inst_mem_resp #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pc_valid_i(pc_valid), .pc_ready_o(pc_ready), .pc_i(pc),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .inst_data_o(inst_data), .inst_pc_o(inst_pc),
    .flush_i(flush), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
`ifdef INST_MEM_ERR_EN
    , .inst_err_o(inst_err)
`endif
  );

  // Model: every accepted fetch is one queue entry until it is consumed; it becomes
  // visible at the head one edge after its accept edge.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
    int          vis;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mmem [2**AW];
  int          cyc, checks, failures, n_acc, n_resp;
  bit          last_acc, last_pop;
  logic        exp_ready, exp_valid, exp_err;
  logic [31:0] exp_data, exp_pc;

  task automatic tick();
    bit acc, pop, err;
    ent_t e;
    acc = pc_valid && !rst && (q.size() < DEPTH);
    pop = (q.size() > 0) && (q[0].vis <= cyc) && inst_ready;
    @(posedge clk);
    cyc++;
    if (rst || flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
`ifdef INST_MEM_ERR_EN
        err = (pc[1:0] != 0) || (pc >= 32'(4 * 2**AW));
`else
        err = 1'b0;
`endif
        e.pc = pc; e.err = err; e.vis = cyc + 1;
        e.data = err ? NOP : mmem[(pc / 4) % (2**AW)];
        q.push_back(e);
      end
    end
    if (wr_en) mmem[(wr_addr / 4) % (2**AW)] = wr_data;
    last_acc = acc && !rst && !flush;
    last_pop = pop && !rst && !flush;
    n_acc  += int'(last_acc);
    n_resp += int'(last_pop);
    #1;
    exp_ready = !rst && (q.size() < DEPTH);
    exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
    exp_data  = exp_valid ? q[0].data : 32'd0;
    exp_pc    = exp_valid ? q[0].pc : 32'd0;
    exp_err   = exp_valid ? q[0].err : 1'b0;
  endtask

  task automatic idle_inputs();
    pc_valid = 0; pc = 0; inst_ready = 0; flush = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    checks++;
    if (pc_ready !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'd0 || inst_pc !== 32'd0) begin
      failures++;
      $display("FAIL reset: ready=%b valid=%b data=%h pc=%h, required 0/0/0/0", pc_ready, inst_valid, inst_data, inst_pc);
    end
    rst = 0;
    tick();
    checks++;
    if (pc_ready !== 1'b1 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b valid=%b, required 1/0", pc_ready, inst_valid);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 2**AW; i++) begin
      wr_en = 1; wr_addr = i * 4;
      wr_data = (i == 0) ? 32'h0050_0093 : (i == 1) ? 32'h00A0_0113 : $urandom;
      tick();
    end
    wr_en = 0;
  endtask

  task automatic test_basic();
    inst_ready = 1; pc_valid = 1; pc = 32'h0;
    tick();
    pc = 32'h4;
    tick();
    pc_valid = 0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0050_0093) begin
      failures++;
      $display("FAIL basic_first: valid=%b pc=%h data=%h, required 1/00000000/00500093", inst_valid, inst_pc, inst_data);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== 32'h00A0_0113) begin
      failures++;
      $display("FAIL basic_second: valid=%b pc=%h data=%h, required 1/00000004/00a00113", inst_valid, inst_pc, inst_data);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain: valid=%b, required 0", inst_valid);
    end
  endtask

  task automatic test_backpressure();
    int a0, r0;
    inst_ready = 0; pc_valid = 1; pc = 32'h10;
    a0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (last_acc) pc = pc + 4;
      checks++;
      if (pc_ready !== exp_ready || inst_valid !== exp_valid || inst_pc !== exp_pc || inst_data !== exp_data) begin
        failures++;
        $display("FAIL bp_stall cyc%0d: rdy=%b vld=%b pc=%h data=%h, required %b/%b/%h/%h",
                 i, pc_ready, inst_valid, inst_pc, inst_data, exp_ready, exp_valid, exp_pc, exp_data);
      end
    end
    checks++;
    if (n_acc - a0 !== 3 || pc_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accepts: accepts=%0d ready=%b, required 3/0", n_acc - a0, pc_ready);
    end
    pc_valid = 0; inst_ready = 1;
    r0 = n_resp;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (pc_ready !== exp_ready || inst_valid !== exp_valid || inst_pc !== exp_pc || inst_data !== exp_data) begin
        failures++;
        $display("FAIL bp_drain cyc%0d: rdy=%b vld=%b pc=%h data=%h, required %b/%b/%h/%h",
                 i, pc_ready, inst_valid, inst_pc, inst_data, exp_ready, exp_valid, exp_pc, exp_data);
      end
    end
    checks++;
    if (n_resp - r0 !== 3) begin
      failures++;
      $display("FAIL bp_responses: got %0d, required 3", n_resp - r0);
    end
  endtask

  task automatic test_stream();
    int a0, r0;
    inst_ready = 1; pc_valid = 1; pc = 32'h40;
    a0 = n_acc; r0 = n_resp;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pc_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready cyc%0d: ready=%b, required 1", i, pc_ready);
      end
      tick();
      pc = pc + 4;
    end
    pc_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inst_valid !== exp_valid || inst_pc !== exp_pc || inst_data !== exp_data) begin
        failures++;
        $display("FAIL stream_tail cyc%0d: vld=%b pc=%h data=%h, required %b/%h/%h",
                 i, inst_valid, inst_pc, inst_data, exp_valid, exp_pc, exp_data);
      end
    end
    checks++;
    if (n_acc - a0 !== 8 || n_resp - r0 !== 8) begin
      failures++;
      $display("FAIL stream_counts: accepts=%0d responses=%0d, required 8/8", n_acc - a0, n_resp - r0);
    end
  endtask

  task automatic test_flush();
    int r0;
    logic [31:0] got_pc, got_data;
    inst_ready = 0; pc_valid = 1; pc = 32'h100;
    tick(); pc = 32'h104;
    tick(); pc_valid = 0;
    tick();
    flush = 1; pc_valid = 1; pc = 32'h20;
    tick();
    flush = 0; pc_valid = 0;
    checks++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_clear: valid=%b ready=%b, required 0/1", inst_valid, pc_ready);
    end
    inst_ready = 1; pc_valid = 1; pc = 32'h8;
    r0 = n_resp; got_pc = 32'hx; got_data = 32'hx;
    tick(); pc_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (inst_valid) begin got_pc = inst_pc; got_data = inst_data; end
      tick();
    end
    checks++;
    if (n_resp - r0 !== 1 || got_pc !== 32'h8 || got_data !== mmem[2]) begin
      failures++;
      $display("FAIL flush_after: responses=%0d pc=%h data=%h, required 1/00000008/%h", n_resp - r0, got_pc, got_data, mmem[2]);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] old;
    old = mmem[3];
    inst_ready = 1; pc_valid = 1; pc = 32'hC;
    wr_en = 1; wr_addr = 32'hC; wr_data = 32'hDEAD_BEEF;
    tick();
    pc_valid = 0; wr_en = 0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_data !== old) begin
      failures++;
      $display("FAIL rdw_old: valid=%b data=%h, required 1/%h", inst_valid, inst_data, old);
    end
    pc_valid = 1;
    tick();
    pc_valid = 0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rdw_new: valid=%b data=%h, required 1/deadbeef", inst_valid, inst_data);
    end
    tick();
  endtask

  task automatic test_addr_err();
    inst_ready = 1; pc_valid = 1;
`ifdef INST_MEM_ERR_EN
    pc = 32'h6;
    tick(); pc_valid = 0; tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_err !== 1'b1 || inst_data !== NOP || inst_pc !== 32'h6) begin
      failures++;
      $display("FAIL err_misaligned: vld=%b err=%b data=%h pc=%h, required 1/1/00000013/00000006", inst_valid, inst_err, inst_data, inst_pc);
    end
    pc_valid = 1; pc = 32'h1000;
    tick(); pc_valid = 0; tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_err !== 1'b1 || inst_data !== NOP) begin
      failures++;
      $display("FAIL err_range: vld=%b err=%b data=%h, required 1/1/00000013", inst_valid, inst_err, inst_data);
    end
`else
    pc = 32'h1000;
    tick(); pc_valid = 0; tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_data !== mmem[0] || inst_pc !== 32'h1000) begin
      failures++;
      $display("FAIL wrap: vld=%b data=%h pc=%h, required 1/%h/00001000", inst_valid, inst_data, inst_pc, mmem[0]);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      pc_valid   = ($urandom_range(0, 9) < 7);
      inst_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 99) < 3);
      rst        = ($urandom_range(0, 199) == 0);
      wr_en      = ($urandom_range(0, 9) == 0);
      wr_addr    = $urandom_range(0, 63) * 4;
      wr_data    = $urandom;
      case ($urandom_range(0, 3))
        0:       pc = $urandom;
        1:       pc = $urandom_range(0, 4095) & ~32'h3;
        default: pc = $urandom_range(0, 63) * 4;
      endcase
      tick();
      checks++;
      if (pc_ready !== exp_ready || inst_valid !== exp_valid || inst_pc !== exp_pc || inst_data !== exp_data
`ifdef INST_MEM_ERR_EN
          || inst_err !== exp_err
`endif
         ) begin
        failures++;
        $display("FAIL random cyc%0d: rdy=%b vld=%b pc=%h data=%h, required %b/%b/%h/%h",
                 i, pc_ready, inst_valid, inst_pc, inst_data, exp_ready, exp_valid, exp_pc, exp_data);
      end
    end
    idle_inputs();
    rst = 0;
    tick();
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0; n_acc = 0; n_resp = 0;
    test_reset();
    preload();
    test_basic();
    test_backpressure();
    test_stream();
    test_flush();
    test_read_during_write();
    test_addr_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
